// File: rtl/audio_transport_ctrl.sv
// Record/play transport controller: decodes the run/rec/play switch levels into
// a six-state transport FSM and drives the SRAM sample address and strobes.
//
// Strobe semantics: o_we / o_re are single-cycle, mutually exclusive pulses,
// issued exactly one cycle after the i_tick that caused them. o_addr is only
// meaningful while one of them is high. o_done pulses together with the final
// strobe of a recording (memory full) or a playback (end reached). In that same
// cycle o_state already reads STOP.
module audio_transport_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int SPEED_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_rec,
    input  logic              i_ply,
    input  logic              i_fast,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic              i_tick,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic              o_re,
    output logic [ADDR_W:0]   o_len,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_RECORD     = 3'd1,
        S_PLAY       = 3'd2,
        S_REC_PAUSE  = 3'd3,
        S_PLAY_PAUSE = 3'd4,
        S_STOP       = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CMD_STOP   = 3'd0,
        CMD_REC    = 3'd1,
        CMD_PLAY   = 3'd2,
        CMD_RPAUSE = 3'd3,
        CMD_PPAUSE = 3'd4
    } cmd_t;

    state_t             state, state_nxt;
    cmd_t               cmd;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W:0]    rd_ptr;      // one spare bit so a fast skip past the end cannot overflow
    logic [SPEED_W-1:0] rep_cnt;
    logic [ADDR_W:0]    speed_ext;
    logic [ADDR_W:0]    rd_next;
    logic               rep_wrap;
    logic               idle_state;
    logic               start_rec, start_ply;
    logic               rec_fire, ply_fire;
    logic               rec_last, ply_last;

    assign o_state = state;

    // Switch decode: only the exact patterns give a command, anything else means stop.
    always_comb begin
        cmd = CMD_STOP;
        case ({i_run, i_rec, i_ply})
            3'b110:  cmd = CMD_REC;
            3'b101:  cmd = CMD_PLAY;
            3'b010:  cmd = CMD_RPAUSE;
            3'b001:  cmd = CMD_PPAUSE;
            default: cmd = CMD_STOP;
        endcase
    end

    // Per-tick datapath decisions; a tick only counts while the state's own command is still held.
    always_comb begin
        idle_state = (state == S_INIT) || (state == S_STOP);
        start_rec  = idle_state && (cmd == CMD_REC);
        start_ply  = idle_state && (cmd == CMD_PLAY) && (o_len != '0);
        rec_fire   = (state == S_RECORD) && (cmd == CMD_REC) && i_tick;
        ply_fire   = (state == S_PLAY) && (cmd == CMD_PLAY) && i_tick;
        rec_last   = rec_fire && (wr_ptr == {ADDR_W{1'b1}});
        speed_ext  = {{(ADDR_W + 1 - SPEED_W){1'b0}}, i_speed};
        rep_wrap   = (rep_cnt == i_speed);
        if (i_fast)
            rd_next = rd_ptr + speed_ext + (ADDR_W + 1)'(1);
        else if (rep_wrap)
            rd_next = rd_ptr + (ADDR_W + 1)'(1);
        else
            rd_next = rd_ptr;
        ply_last   = ply_fire && (rd_next >= o_len);
    end

    // Next-state logic; end-of-memory or end-of-recording forces STOP.
    always_comb begin
        state_nxt = S_STOP;
        case (state)
            S_INIT, S_STOP: begin
                if (start_rec)      state_nxt = S_RECORD;
                else if (start_ply) state_nxt = S_PLAY;
                else                state_nxt = S_STOP;
            end
            S_RECORD: begin
                if (cmd == CMD_REC)         state_nxt = S_RECORD;
                else if (cmd == CMD_RPAUSE) state_nxt = S_REC_PAUSE;
                else                        state_nxt = S_STOP;
            end
            S_REC_PAUSE: begin
                if (cmd == CMD_RPAUSE)   state_nxt = S_REC_PAUSE;
                else if (cmd == CMD_REC) state_nxt = S_RECORD;
                else                     state_nxt = S_STOP;
            end
            S_PLAY: begin
                if (cmd == CMD_PLAY)        state_nxt = S_PLAY;
                else if (cmd == CMD_PPAUSE) state_nxt = S_PLAY_PAUSE;
                else                        state_nxt = S_STOP;
            end
            S_PLAY_PAUSE: begin
                if (cmd == CMD_PPAUSE)    state_nxt = S_PLAY_PAUSE;
                else if (cmd == CMD_PLAY) state_nxt = S_PLAY;
                else                      state_nxt = S_STOP;
            end
            default: state_nxt = S_STOP;
        endcase
        if (rec_last || ply_last)
            state_nxt = S_STOP;
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_INIT;
        else       state <= state_nxt;
    end

    // Pointers, recording length and registered strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rep_cnt <= '0;
            o_len   <= '0;
            o_addr  <= '0;
            o_we    <= 1'b0;
            o_re    <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_we   <= rec_fire;
            o_re   <= ply_fire;
            o_done <= rec_last || ply_last;
            if (start_rec) begin
                wr_ptr <= '0;
                o_len  <= '0;
            end
            if (start_ply) begin
                rd_ptr  <= '0;
                rep_cnt <= '0;
            end
            if (rec_fire) begin
                o_addr <= wr_ptr;
                wr_ptr <= wr_ptr + ADDR_W'(1);
                o_len  <= {1'b0, wr_ptr} + (ADDR_W + 1)'(1);
            end
            if (ply_fire) begin
                o_addr <= rd_ptr[ADDR_W-1:0];
                rd_ptr <= rd_next;
                if (i_fast || rep_wrap) rep_cnt <= '0;
                else                    rep_cnt <= rep_cnt + SPEED_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_audio_transport_ctrl.sv
// Bench for audio_transport_ctrl with a 16-sample memory: directed scenarios
// followed by randomized record/play rounds checked against an address-list model.
module tb_audio_transport_ctrl;

    localparam int AW  = 4;
    localparam int SW  = 3;
    localparam int CAP = 1 << AW;

    localparam logic [2:0] SW_REC    = 3'b110;
    localparam logic [2:0] SW_PLAY   = 3'b101;
    localparam logic [2:0] SW_RPAUSE = 3'b010;
    localparam logic [2:0] SW_PPAUSE = 3'b001;
    localparam logic [2:0] SW_STOP   = 3'b000;

    localparam logic [31:0] ST_INIT = 0, ST_RECORD = 1, ST_PLAY = 2;
    localparam logic [31:0] ST_RPAUSE = 3, ST_PPAUSE = 4, ST_STOP = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          run, rec, ply, fast, tick;
    logic [SW-1:0] speed;
    logic [2:0]    dut_state;
    logic [AW-1:0] addr;
    logic          we, re, done;
    logic [AW:0]   len;

    int checks   = 0;
    int failures = 0;
    logic [AW:0] exp_q[$];

    audio_transport_ctrl #(.ADDR_W(AW), .SPEED_W(SW)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_run  (run),
        .i_rec  (rec),
        .i_ply  (ply),
        .i_fast (fast),
        .i_speed(speed),
        .i_tick (tick),
        .o_state(dut_state),
        .o_addr (addr),
        .o_we   (we),
        .o_re   (re),
        .o_len  (len),
        .o_done (done)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic [2:0] s);
        {run, rec, ply} = s;
    endtask

    task automatic cmd_step(input logic [2:0] s);
        set_sw(s);
        step();
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_we", 32'(we), 0);
            chk("idle_re", 32'(re), 0);
        end
    endtask

    task automatic tick_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic rec_tick(input int a, input bit last);
        tick_step();
        chk("rec_we", 32'(we), 1);
        chk("rec_re", 32'(re), 0);
        chk("rec_addr", 32'(addr), 32'(a));
        chk("rec_done", 32'(done), 32'(last));
    endtask

    task automatic ply_tick(input int a, input bit last);
        tick_step();
        chk("ply_re", 32'(re), 1);
        chk("ply_we", 32'(we), 0);
        chk("ply_addr", 32'(addr), 32'(a));
        chk("ply_done", 32'(done), 32'(last));
    endtask

    // Record n samples from STOP/INIT, with optional random idle gaps, then return to STOP.
    task automatic record_n(input int n, input bit gaps);
        cmd_step(SW_REC);
        chk("rec_enter", 32'(dut_state), ST_RECORD);
        chk("rec_len_clr", 32'(len), 0);
        for (int i = 0; i < n; i++) begin
            if (gaps) idle_chk($urandom_range(0, 2));
            rec_tick(i, i == CAP - 1);
        end
        chk("rec_len", 32'(len), 32'(n));
        chk("rec_state", 32'(dut_state), (n == CAP) ? ST_STOP : ST_RECORD);
        cmd_step(SW_STOP);
        chk("rec_stop", 32'(dut_state), ST_STOP);
    endtask

    // Reference model: the address list a whole playback must produce.
    // Fast: every (speed+1)-th sample. Slow: every sample repeated speed+1 times.
    function automatic void build_play(input int n, input int spd, input bit fst);
        exp_q.delete();
        if (fst) begin
            for (int a = 0; a < n; a += spd + 1) exp_q.push_back((AW + 1)'(a));
        end else begin
            for (int a = 0; a < n; a++)
                for (int r = 0; r <= spd; r++) exp_q.push_back((AW + 1)'(a));
        end
    endfunction

    task automatic play_all(input int n, input int spd, input bit fst, input bit gaps);
        logic [AW:0] a;
        build_play(n, spd, fst);
        speed = SW'(spd);
        fast  = fst;
        cmd_step(SW_PLAY);
        chk("ply_enter", 32'(dut_state), ST_PLAY);
        while (exp_q.size() > 0) begin
            a = exp_q.pop_front();
            if (gaps) idle_chk($urandom_range(0, 2));
            ply_tick(int'(a), exp_q.size() == 0);
        end
        chk("ply_end_state", 32'(dut_state), ST_STOP);
        cmd_step(SW_STOP);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; fast = 1'b0; speed = '0;
        set_sw(SW_REC);

        // Reset state, then RECORD one cycle after release; five samples at 0..4.
        #2;
        chk("rst_state", 32'(dut_state), ST_INIT);
        chk("rst_len", 32'(len), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_re", 32'(re), 0);
        chk("rst_done", 32'(done), 0);
        #1 rst = 1'b0;
        step();
        chk("t1_record", 32'(dut_state), ST_RECORD);
        for (int i = 0; i < 5; i++) rec_tick(i, 1'b0);
        chk("t1_len", 32'(len), 5);
        cmd_step(SW_RPAUSE);
        chk("t1_rpause", 32'(dut_state), ST_RPAUSE);
        tick_step();
        chk("t1_pause_we", 32'(we), 0);
        cmd_step(SW_REC);
        chk("t1_resume", 32'(dut_state), ST_RECORD);
        rec_tick(5, 1'b0);
        chk("t1_len6", 32'(len), 6);
        cmd_step(SW_STOP);
        chk("t1_stop", 32'(dut_state), ST_STOP);

        // Fill the whole memory: last write at 15 with done, length 16.
        record_n(CAP, 1'b0);

        // Fast play, skip by 3.
        record_n(10, 1'b0);
        play_all(10, 2, 1'b1, 1'b0);

        // Slow play, each sample twice.
        record_n(3, 1'b0);
        play_all(3, 1, 1'b0, 1'b0);

        // Pause and resume mid-playback.
        record_n(10, 1'b0);
        speed = '0; fast = 1'b0;
        cmd_step(SW_PLAY);
        for (int i = 0; i < 5; i++) ply_tick(i, 1'b0);
        cmd_step(SW_PPAUSE);
        chk("t5_ppause", 32'(dut_state), ST_PPAUSE);
        tick_step();
        chk("t5_pause_re", 32'(re), 0);
        cmd_step(SW_PLAY);
        chk("t5_resume", 32'(dut_state), ST_PLAY);
        ply_tick(5, 1'b0);
        cmd_step(SW_STOP);
        chk("t5_stop", 32'(dut_state), ST_STOP);

        // Asynchronous reset clears the recording; play with nothing recorded stays STOP.
        rst = 1'b1;
        #2;
        chk("t6_rst_state", 32'(dut_state), ST_INIT);
        chk("t6_rst_len", 32'(len), 0);
        rst = 1'b0;
        cmd_step(SW_PLAY);
        chk("t6_empty_play", 32'(dut_state), ST_STOP);
        tick_step();
        chk("t6_empty_re", 32'(re), 0);
        chk("t6_empty_state", 32'(dut_state), ST_STOP);

        // A tick in the same cycle as the exit command is dropped.
        record_n(4, 1'b0);
        speed = '0; fast = 1'b1;
        cmd_step(SW_PLAY);
        ply_tick(0, 1'b0);
        set_sw(SW_STOP);
        tick_step();
        chk("t6_exit_tick_re", 32'(re), 0);
        chk("t6_exit_state", 32'(dut_state), ST_STOP);

        // Randomized record/play rounds against the address-list model.
        for (int r = 0; r < 8; r++) begin
            int n;
            int spd;
            bit fst;
            n   = $urandom_range(1, CAP);
            spd = $urandom_range(0, (1 << SW) - 1);
            fst = 1'($urandom_range(0, 1));
            record_n(n, 1'b1);
            play_all(n, spd, fst, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
